pll_reset_sequencer: RTL and testbench



---
 rtl/pll_seq_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/pll_reset_sequencer.sv | 137 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and default timing for the PLL reset sequencer.
// Defaults are derived from the 27 MHz board reference clock.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_seq_state_t;

    localparam int unsigned CLK_REF_HZ = 27_000_000;

    // 1 us of PLL RESET pulse
    localparam int unsigned PLL_RESET_CYCLES_1US = CLK_REF_HZ / 1_000_000;
    // 10 ms allowed for LOCK per attempt
    localparam int unsigned LOCK_TIMEOUT_CYCLES_10MS = CLK_REF_HZ / 100;
    // 100 us of continuous LOCK before release
    localparam int unsigned LOCK_STABLE_CYCLES_100US = CLK_REF_HZ / 10_000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Output resets to 0 asynchronously with rst_n.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous input through two flops to settle metastability
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Supervises the rPLL: pulses RESET, waits for LOCK, qualifies it over a
// stable window, then releases system reset. Retries on lock timeout and
// relocks on lock loss or request. Runs on the free-running reference clock.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned PLL_RESET_CYCLES    = PLL_RESET_CYCLES_1US,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_CYCLES_10MS,
    parameter int unsigned LOCK_STABLE_CYCLES  = LOCK_STABLE_CYCLES_100US,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned CNT_WIDTH           = 20,
    parameter int unsigned RETRY_WIDTH         = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pll_lock_i,
    input  logic                   relock_i,
    output logic                   pll_reset_o,
    output logic                   sys_rst_n_o,
    output logic                   locked_o,
    output logic                   fail_o,
    output logic [RETRY_WIDTH-1:0] retry_cnt_o,
    output logic [2:0]             state_o
);

    localparam logic [CNT_WIDTH-1:0]   RST_LAST    = CNT_WIDTH'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]   TMO_LAST    = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0]   STB_LAST    = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_WIDTH-1:0] RETRY_LIMIT = RETRY_WIDTH'(MAX_RETRIES);
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [RETRY_WIDTH-1:0] RETRY_ONE   = RETRY_WIDTH'(1);

    logic                   lock_s;
    pll_seq_state_t         state;
    pll_seq_state_t         state_nxt;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [CNT_WIDTH-1:0]   cnt_nxt;
    logic [RETRY_WIDTH-1:0] retries;
    logic [RETRY_WIDTH-1:0] retries_nxt;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock_i),
        .q     (lock_s)
    );

    // Next-state, counter and retry decisions; every terminal compare
    // clears or holds the counter so it never wraps
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        retries_nxt = retries;
        unique case (state)
            ST_PLL_RST: begin
                if (cnt == RST_LAST) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == TMO_LAST) begin
                    cnt_nxt = '0;
                    if (retries == RETRY_LIMIT) begin
                        state_nxt = ST_FAIL;
                    end else begin
                        state_nxt   = ST_PLL_RST;
                        retries_nxt = retries + RETRY_ONE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STB_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (!lock_s || relock_i) begin
                    state_nxt   = ST_PLL_RST;
                    cnt_nxt     = '0;
                    retries_nxt = '0;
                end
            end
            ST_FAIL: begin
                if (relock_i) begin
                    state_nxt   = ST_PLL_RST;
                    cnt_nxt     = '0;
                    retries_nxt = '0;
                end
            end
            default: begin
                state_nxt   = ST_PLL_RST;
                cnt_nxt     = '0;
                retries_nxt = '0;
            end
        endcase
    end

    // State register with outputs decoded from next-state so they switch on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_PLL_RST;
            cnt         <= '0;
            retries     <= '0;
            pll_reset_o <= 1'b1;
            sys_rst_n_o <= 1'b0;
            locked_o    <= 1'b0;
            fail_o      <= 1'b0;
            state_o     <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            retries     <= retries_nxt;
            pll_reset_o <= (state_nxt == ST_PLL_RST);
            sys_rst_n_o <= (state_nxt == ST_RUN);
            locked_o    <= (state_nxt == ST_RUN);
            fail_o      <= (state_nxt == ST_FAIL);
            state_o     <= state_nxt;
        end
    end

    assign retry_cnt_o = retries;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_pll_reset_sequencer;

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic       pll_lock_i;
    logic       relock_i;
    logic       pll_reset_o;
    logic       sys_rst_n_o;
    logic       locked_o;
    logic       fail_o;
    logic [1:0] retry_cnt_o;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    pll_reset_sequencer #(
        .PLL_RESET_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (32),
        .LOCK_STABLE_CYCLES  (8),
        .MAX_RETRIES         (2),
        .CNT_WIDTH           (20),
        .RETRY_WIDTH         (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_lock_i  (pll_lock_i),
        .relock_i    (relock_i),
        .pll_reset_o (pll_reset_o),
        .sys_rst_n_o (sys_rst_n_o),
        .locked_o    (locked_o),
        .fail_o      (fail_o),
        .retry_cnt_o (retry_cnt_o),
        .state_o     (state_o)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // state, PLL reset and system reset in one go
    task automatic check_core(input string tag, input int st, input int prst, input int srst);
        check_eq({tag, "_state"}, 32'(state_o), 32'(st));
        check_eq({tag, "_pllrst"}, 32'(pll_reset_o), 32'(prst));
        check_eq({tag, "_sysrst"}, 32'(sys_rst_n_o), 32'(srst));
    endtask

    initial begin
        clk        = 1'b0;
        clk_en     = 1'b1;
        rst_n      = 1'b0;
        pll_lock_i = 1'b0;
        relock_i   = 1'b0;

        // Reset values
        tick(3);
        check_core("rst", 0, 1, 0);
        check_eq("rst_locked", 32'(locked_o), 0);
        check_eq("rst_fail", 32'(fail_o), 0);
        check_eq("rst_retry", 32'(retry_cnt_o), 0);

        // 1. Normal bring-up
        rst_n = 1'b1;
        tick(3);
        check_core("t1_prst3", 0, 1, 0);
        tick(1);
        check_core("t1_prst4", 1, 0, 0);
        tick(2);
        pll_lock_i = 1'b1;
        tick(2);
        check_eq("t1_k1_state", 32'(state_o), 1);
        tick(1);
        check_eq("t1_k2_state", 32'(state_o), 2);
        tick(7);
        check_core("t1_k9", 2, 0, 0);
        tick(1);
        check_core("t1_k10", 3, 0, 1);
        check_eq("t1_locked", 32'(locked_o), 1);

        // 4. Lock loss in RUN
        pll_lock_i = 1'b0;
        tick(2);
        check_core("t4_k1", 3, 0, 1);
        tick(1);
        check_core("t4_k2", 0, 1, 0);
        check_eq("t4_locked", 32'(locked_o), 0);
        check_eq("t4_retry", 32'(retry_cnt_o), 0);
        tick(3);
        check_core("t4_prst", 0, 1, 0);
        tick(1);
        check_core("t4_wait", 1, 0, 0);
        pll_lock_i = 1'b1;
        tick(2);
        check_eq("t4_k1_state", 32'(state_o), 1);
        tick(1);
        check_eq("t4_k2_state", 32'(state_o), 2);
        tick(8);
        check_core("t4_run", 3, 0, 1);

        // 5a. relock_i in RUN
        relock_i = 1'b1;
        tick(1);
        relock_i   = 1'b0;
        pll_lock_i = 1'b0;
        check_core("t5_run_relock", 0, 1, 0);
        check_eq("t5_run_fail", 32'(fail_o), 0);
        check_eq("t5_run_retry", 32'(retry_cnt_o), 0);
        tick(4);
        check_eq("t5_wait_state", 32'(state_o), 1);
        // 5c. relock_i in WAIT_LOCK is ignored
        relock_i = 1'b1;
        tick(1);
        relock_i = 1'b0;
        check_core("t5_wait_relock", 1, 0, 0);
        tick(1);
        check_eq("t5_wait_hold", 32'(state_o), 1);

        // 2. Glitch in STABLE
        pll_lock_i = 1'b1;
        tick(2);
        check_eq("t2_k1_state", 32'(state_o), 1);
        tick(1);
        check_eq("t2_k2_state", 32'(state_o), 2);
        tick(2);
        pll_lock_i = 1'b0;
        tick(1);
        pll_lock_i = 1'b1;
        tick(1);
        check_eq("t2_k6_state", 32'(state_o), 2);
        tick(1);
        check_core("t2_k7", 1, 0, 0);
        tick(1);
        check_eq("t2_k8_state", 32'(state_o), 2);
        tick(7);
        check_core("t2_k15", 2, 0, 0);
        tick(1);
        check_core("t2_k16", 3, 0, 1);

        // 3. Timeout, retries and FAIL
        pll_lock_i = 1'b0;
        tick(2);
        check_eq("t3_k1_state", 32'(state_o), 3);
        tick(1);
        check_core("t3_k2", 0, 1, 0);
        tick(4);
        check_core("t3_wait0", 1, 0, 0);
        tick(31);
        check_eq("t3_w0_end_state", 32'(state_o), 1);
        check_eq("t3_w0_end_retry", 32'(retry_cnt_o), 0);
        tick(1);
        check_core("t3_retry1", 0, 1, 0);
        check_eq("t3_retry1_cnt", 32'(retry_cnt_o), 1);
        tick(3);
        check_eq("t3_prst1_hold", 32'(pll_reset_o), 1);
        tick(1);
        check_core("t3_wait1", 1, 0, 0);
        tick(31);
        check_eq("t3_w1_end_retry", 32'(retry_cnt_o), 1);
        tick(1);
        check_core("t3_retry2", 0, 1, 0);
        check_eq("t3_retry2_cnt", 32'(retry_cnt_o), 2);
        tick(4);
        check_eq("t3_wait2_state", 32'(state_o), 1);
        tick(31);
        check_eq("t3_w2_end_state", 32'(state_o), 1);
        check_eq("t3_w2_end_fail", 32'(fail_o), 0);
        tick(1);
        check_core("t3_fail", 4, 0, 0);
        check_eq("t3_fail_flag", 32'(fail_o), 1);
        check_eq("t3_fail_retry", 32'(retry_cnt_o), 2);
        tick(5);
        check_eq("t3_fail_hold", 32'(state_o), 4);
        check_eq("t3_fail_hold_flag", 32'(fail_o), 1);

        // 5b. relock_i in FAIL
        relock_i = 1'b1;
        tick(1);
        relock_i = 1'b0;
        check_core("t5_fail_relock", 0, 1, 0);
        check_eq("t5_fail_clr", 32'(fail_o), 0);
        check_eq("t5_fail_retry", 32'(retry_cnt_o), 0);

        // 6. Async reset mid-STABLE with the clock stopped
        tick(4);
        check_eq("t6_wait_state", 32'(state_o), 1);
        pll_lock_i = 1'b1;
        tick(3);
        check_eq("t6_stable_state", 32'(state_o), 2);
        tick(2);
        @(negedge clk);
        clk_en = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_core("t6_async", 0, 1, 0);
        check_eq("t6_async_retry", 32'(retry_cnt_o), 0);
        #5;
        rst_n = 1'b1;
        #2;
        clk_en = 1'b1;
        tick(3);
        check_eq("t6_prst_state", 32'(state_o), 0);
        tick(1);
        check_eq("t6_wait_state2", 32'(state_o), 1);
        tick(1);
        check_eq("t6_stable_state2", 32'(state_o), 2);
        tick(7);
        check_core("t6_pre_run", 2, 0, 0);
        tick(1);
        check_core("t6_run", 3, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
